// File: rtl/serpent_round_ctrl.sv
// -----------------------------------------------------------------------------
// serpent_round_ctrl
//
// Iterative Serpent encryption sequencer. Runs the bitslice datapath through
// all 32 rounds, one round per cycle. Each round mixes in subkey K_r, applies
// S-box (r mod 8) and then the linear transform. Round 31 skips the linear
// transform, and the extra step r=32 only mixes in K32. Subkeys are fetched by
// index from an external key store, and the data must arrive in the same
// cycle as the request.
//
// Word order for all 128-bit buses: x0=[31:0], x1=[63:32], x2=[95:64],
// x3=[127:96] (bitslice order, no IP/FP).
//
// Configuration macro: SERPENT_KEY_STALL_EN
//   defined   : a round advances only in a cycle where i_rk_valid=1. The index
//               and the state register hold while waiting.
//   undefined : i_rk_valid is ignored, and every RUN cycle advances. Accept to
//               output valid then takes a fixed 34 cycles.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   plaintext valid
//   o_in_ready   plaintext ready (IDLE only)
//   i_in_data    plaintext block
//   o_rk_req     subkey request (RUN)
//   o_rk_idx     subkey index 0..32
//   i_rk_valid   subkey valid (used only with SERPENT_KEY_STALL_EN)
//   i_rk_data    subkey data
//   o_out_valid  ciphertext valid (DONE)
//   i_out_ready  consumer ready
//   o_out_data   ciphertext, held stable until the handshake completes
//   o_busy       high in any state other than IDLE
// -----------------------------------------------------------------------------
module serpent_round_ctrl #(
   // Fixed at 32; other values are unsupported.
   parameter int unsigned ROUNDS = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [127:0] i_in_data,
   output logic         o_rk_req,
   output logic [5:0]   o_rk_idx,
   input  logic         i_rk_valid,
   input  logic [127:0] i_rk_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [127:0] o_out_data,
   output logic         o_busy
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Index of the final key-only step, and of the round that skips LT.
   localparam logic [5:0] LastIdx   = 6'(ROUNDS);
   localparam logic [5:0] NoLtRound = 6'(ROUNDS - 1);

   // Serpent S-boxes S0..S7, addressed as {box, nibble}.
   localparam logic [3:0] SBOX [128] = '{
      4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11,
      4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12,
      4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10,
      4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4,
      4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15,
      4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2,
      4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,
      4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14,
      4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,
      4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13,
      4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12,
      4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1,
      4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11,
      4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0,
      4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11,
      4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6
   };

   // One bitslice S-box layer. Bit j of each word forms one nibble: x0 is the
   // LSB and x3 is the MSB.
   function automatic logic [127:0] sbox_layer(input logic [2:0] box, input logic [127:0] x);
      logic [3:0]   nib;
      logic [3:0]   y;
      logic [127:0] res;
      res = '0;
      for (int j = 0; j < 32; j++) begin
         nib         = {x[96+j], x[64+j], x[32+j], x[j]};
         y           = SBOX[{box, nib}];
         res[j]      = y[0];
         res[32+j]   = y[1];
         res[64+j]   = y[2];
         res[96+j]   = y[3];
      end
      return res;
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] a, input int unsigned k);
      return (a << k) | (a >> (32 - k));
   endfunction

   function automatic logic [127:0] lin_trans(input logic [127:0] x);
      logic [31:0] x0, x1, x2, x3;
      x0 = x[31:0];
      x1 = x[63:32];
      x2 = x[95:64];
      x3 = x[127:96];
      x0 = rotl(x0, 13);
      x2 = rotl(x2, 3);
      x1 = x1 ^ x0 ^ x2;
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = rotl(x1, 1);
      x3 = rotl(x3, 7);
      x0 = x0 ^ x1 ^ x3;
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = rotl(x0, 5);
      x2 = rotl(x2, 22);
      return {x3, x2, x1, x0};
   endfunction

   state_e       r_state, w_state_next;
   logic [5:0]   r_round, w_round_next;
   logic [127:0] r_x, w_x_next;
   logic [127:0] r_out, w_out_next;

   logic         w_advance;
   logic [127:0] w_mixed;
   logic [127:0] w_sbox [8];
   logic [127:0] w_sbox_sel;
   logic [127:0] w_lt;

`ifdef SERPENT_KEY_STALL_EN
   assign w_advance = i_rk_valid;
`else
   // Subkey data is valid every RUN cycle, so the valid strobe plays no part.
   logic w_unused_rk_valid;
   assign w_unused_rk_valid = i_rk_valid;
   assign w_advance         = 1'b1;
`endif

   assign w_mixed = r_x ^ i_rk_data;

   // All eight slices are built. Only the one selected by r mod 8 reaches the
   // state register.
   for (genvar b = 0; b < 8; b++) begin : g_sbox
      assign w_sbox[b] = sbox_layer(3'(b), w_mixed);
   end

   assign w_sbox_sel = w_sbox[r_round[2:0]];
   assign w_lt       = lin_trans(w_sbox_sel);

   always_comb begin
      w_state_next = r_state;
      w_round_next = r_round;
      w_x_next     = r_x;
      w_out_next   = r_out;
      o_in_ready   = 1'b0;
      o_busy       = 1'b1;
      o_rk_req     = 1'b0;
      o_out_valid  = 1'b0;

      unique case (r_state)
         StIdle: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b0;
            if (i_in_valid) begin
               w_state_next = StRun;
               w_round_next = '0;
               w_x_next     = i_in_data;
            end
         end
         StRun: begin
            o_rk_req = 1'b1;
            if (w_advance) begin
               if (r_round == LastIdx) begin
                  // Final whitening with K32. The ciphertext is captured here
                  // and stays frozen through DONE.
                  w_state_next = StDone;
                  w_round_next = '0;
                  w_x_next     = w_mixed;
                  w_out_next   = w_mixed;
               end else begin
                  w_round_next = r_round + 6'd1;
                  w_x_next     = (r_round == NoLtRound) ? w_sbox_sel : w_lt;
               end
            end
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   assign o_rk_idx   = r_round;
   assign o_out_data = r_out;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_round <= '0;
         r_x     <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_next;
         r_round <= w_round_next;
         r_x     <= w_x_next;
         r_out   <= w_out_next;
      end
   end

endmodule

// File: tb/tb_serpent_round_ctrl.sv
module tb_serpent_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         rk_req;
   logic [5:0]   rk_idx;
   logic         rk_valid;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [127:0] keys [33];
   int           sb [8][16];
   logic         stall_on = 1'b0;
   int           r7_wait = 0;

   always #5 clk = ~clk;

   serpent_round_ctrl #(.ROUNDS(32)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .o_rk_req    (rk_req),
      .o_rk_idx    (rk_idx),
      .i_rk_valid  (rk_valid),
      .i_rk_data   (rk_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_busy      (busy)
   );

   // Key store answers combinationally.
   assign rk_data = (rk_idx <= 6'd32) ? keys[rk_idx] : '0;

`ifdef SERPENT_KEY_STALL_EN
   // When stalling is enabled, round 7 receives its key only after 3 wait cycles.
   assign rk_valid = !(stall_on && rk_req && rk_idx == 6'd7 && r7_wait < 3);
   always @(posedge clk) begin
      if (stall_on && rk_req && rk_idx == 6'd7) r7_wait <= r7_wait + 1;
      else r7_wait <= 0;
   end
`else
   assign rk_valid = 1'b1;
`endif

   function automatic logic [31:0] rl(input logic [31:0] a, input int k);
      return (a << k) | (a >> (32 - k));
   endfunction

   // Reference Serpent encryption (bitslice order) using the current keys[].
   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
      logic [127:0] v;
      logic [31:0]  x0, x1, x2, x3;
      int           n;
      v = pt;
      for (int r = 0; r < 32; r++) begin
         v = v ^ keys[r];
         x0 = '0; x1 = '0; x2 = '0; x3 = '0;
         for (int j = 0; j < 32; j++) begin
            n = int'({v[96+j], v[64+j], v[32+j], v[j]});
            n = sb[r % 8][n];
            x0[j] = n[0]; x1[j] = n[1]; x2[j] = n[2]; x3[j] = n[3];
         end
         if (r < 31) begin
            x0 = rl(x0, 13); x2 = rl(x2, 3);
            x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
            x1 = rl(x1, 1); x3 = rl(x3, 7);
            x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
            x0 = rl(x0, 5); x2 = rl(x2, 22);
         end
         v = {x3, x2, x1, x0};
      end
      return v ^ keys[32];
   endfunction

   // Caller is at a negedge with the DUT idle. Runs one block end to end.
   task automatic run_block(input logic [127:0] pt, input int exp_lat, input bit rand_ready,
                            input bit poke_busy, output int hold7);
      logic [127:0] exp_ct, held;
      int           k, exp_idx;
      bit           seen, hs;
      exp_ct = ref_encrypt(pt);
      hold7  = 0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready: got %b expected 1", in_ready);
      end
      in_valid  = 1'b1;
      in_data   = pt;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~pt;
      k = 1; exp_idx = 0; seen = 0;
      while (k <= 200 && !seen) begin
         if (out_valid === 1'b1) begin
            seen = 1;
         end else begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL run_flags k=%0d: got busy=%b in_ready=%b expected 1/0", k, busy,
                        in_ready);
            end
            checks++;
            if (rk_req !== 1'b1 || rk_idx !== 6'(exp_idx)) begin
               errors++;
               $display("FAIL rk_idx k=%0d: got req=%b idx=%0d expected 1/%0d", k, rk_req, rk_idx,
                        exp_idx);
            end
            if (rk_idx == 6'd7) hold7++;
            if (rk_valid) exp_idx++;
            in_valid = poke_busy && k >= 5 && k <= 9;
            @(negedge clk);
            k++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (!seen) begin
         errors++; $display("FAIL latency: no out_valid within 200 cycles, expected %0d", exp_lat);
      end else if (k != exp_lat) begin
         errors++; $display("FAIL latency: got %0d expected %0d", k, exp_lat);
      end
      if (seen) begin
         checks++;
         if (out_data !== exp_ct) begin
            errors++; $display("FAIL ciphertext: got %h expected %h", out_data, exp_ct);
         end
         held = out_data;
         hs = 0;
         while (!hs) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL done_hold: got valid=%b data=%h in_ready=%b expected 1/%h/0",
                        out_valid, out_data, in_ready, held);
            end
            hs = rand_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
            out_ready = hs;
            @(negedge clk);
         end
         out_ready = 1'b0;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_exit: got in_ready=%b out_valid=%b busy=%b expected 1/0/0",
                     in_ready, out_valid, busy);
         end
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
             rk_req !== 1'b0 || rk_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b busy=%b ov=%b od=%h req=%b idx=%0d expected idle",
                     in_ready, busy, out_valid, out_data, rk_req, rk_idx);
         end
      end
   endtask

   task automatic test_zero_block;
      int h7;
      for (int i = 0; i < 33; i++) keys[i] = '0;
      run_block('0, 34, 1'b0, 1'b0, h7);
      checks++;
      if (h7 != 1) begin
         errors++; $display("FAIL zero_idx7_hold: got %0d expected 1", h7);
      end
   endtask

   task automatic test_random_blocks;
      int h7;
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < 33; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
         run_block({$urandom, $urandom, $urandom, $urandom}, 34, 1'b1, 1'b0, h7);
      end
   endtask

   task automatic test_mid_reset;
      int  k, h7;
      bit  bad;
      for (int i = 0; i < 33; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      in_data  = 128'h0123456789abcdef_fedcba9876543210;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (rk_idx != 6'd15 && k < 100) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (rk_idx !== 6'd15) begin
         errors++; $display("FAIL reach_r15: got %0d expected 15", rk_idx);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: got rdy=%b busy=%b ov=%b expected 1/0/0", in_ready, busy,
                  out_valid);
      end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL aborted_block: got out_valid/busy activity expected none");
      end
      run_block(128'h00000000ffffffff_5555aaaa3c3cc3c3, 34, 1'b0, 1'b0, h7);
   endtask

   task automatic test_busy_ignore;
      int h7;
      for (int i = 0; i < 33; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
      run_block(128'hdeadbeef_cafef00d_01020304_a5a5a5a5, 34, 1'b0, 1'b1, h7);
   endtask

   task automatic test_back_to_back;
      int h7;
      for (int i = 0; i < 33; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
      run_block(128'h1, 34, 1'b0, 1'b0, h7);
      run_block(128'h8000_0000_0000_0000_0000_0000_0000_0000, 34, 1'b0, 1'b0, h7);
   endtask

   task automatic test_key_stall;
      int h7;
`ifdef SERPENT_KEY_STALL_EN
      stall_on = 1'b1;
      run_block('0, 37, 1'b0, 1'b0, h7);
      stall_on = 1'b0;
      checks++;
      if (h7 != 4) begin
         errors++; $display("FAIL stall_idx7_hold: got %0d expected 4", h7);
      end
`else
      run_block('0, 34, 1'b0, 1'b0, h7);
`endif
   endtask

   initial begin
      sb = '{
         '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
         '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
         '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
         '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
         '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
         '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
         '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
         '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
      };
      for (int i = 0; i < 33; i++) keys[i] = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_zero_block();
      test_random_blocks();
      test_mid_reset();
      test_busy_ignore();
      test_back_to_back();
      for (int i = 0; i < 33; i++) keys[i] = '0;
      test_key_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
